// File: rtl/distortion_pkg.sv
// Shared encodings, reset values and clamp helpers for the distortion controller.
// The RAMP state exists only when DISTORTION_CTRL_RAMP_EN is defined.
package distortion_pkg;

   localparam logic [1:0] MODE_OFF      = 2'd0;
   localparam logic [1:0] MODE_CLIP     = 2'd1;
   localparam logic [1:0] MODE_RECT     = 2'd2;
   localparam logic [1:0] MODE_CLIP_ALT = 2'd3;

   localparam logic signed [15:0] GAIN_MAX  = 16'sd128;
   localparam logic [7:0]         FADE_FULL = 8'd255;
   localparam logic signed [15:0] GAIN_RST  = 16'sd1;
   localparam logic signed [31:0] THR_RST   = 32'sd32767;

`ifdef DISTORTION_CTRL_RAMP_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_FADE_OUT, ST_SWITCH, ST_FADE_IN, ST_RAMP
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_FADE_OUT, ST_SWITCH, ST_FADE_IN
   } state_t;
`endif

   function automatic logic signed [15:0] clamp_gain(input logic signed [15:0] g);
      if (g < 16'sd0)   return 16'sd0;
      if (g > GAIN_MAX) return GAIN_MAX;
      return g;
   endfunction

   function automatic logic signed [31:0] clamp_thr(input logic signed [31:0] t);
      return (t < 32'sd0) ? 32'sd0 : t;
   endfunction

endpackage

// File: rtl/distortion_ctrl_if.sv
// Configuration handshake plus the registered parameter bundle driven to the datapath.
// master = configuration source, slave = controller.
interface distortion_ctrl_if;
   logic               cfg_valid;
   logic               cfg_ready;
   logic signed [15:0] gain_tgt;
   logic signed [31:0] thr_tgt;
   logic [1:0]         mode_tgt;
   logic signed [15:0] gain;
   logic signed [31:0] threshold;
   logic [1:0]         mode;
   logic [7:0]         fade;
   logic               busy;

   modport master (
      output cfg_valid, gain_tgt, thr_tgt, mode_tgt,
      input  cfg_ready, gain, threshold, mode, fade, busy
   );

   modport slave (
      input  cfg_valid, gain_tgt, thr_tgt, mode_tgt,
      output cfg_ready, gain, threshold, mode, fade, busy
   );
endinterface

// File: rtl/distortion_ctrl_param_ramp.sv
// Combinational step of cur toward tgt by STEP, clamped so it never passes tgt.
// BYPASS makes the result jump straight to tgt (used when ramping is compiled out).
module param_ramp #(
   parameter int W      = 16,
   parameter int STEP   = 1,
   parameter bit BYPASS = 1'b0
) (
   input  logic signed [W-1:0] cur,
   input  logic signed [W-1:0] tgt,
   output logic signed [W-1:0] nxt
);
   localparam logic signed [W+1:0] STEP_X = (W+2)'(STEP);
   localparam logic signed [W-1:0] STEP_W = W'(STEP);

   logic signed [W+1:0] diff;

   always_comb begin
      // two guard bits keep tgt - cur exact for any pair of W-bit operands
      diff = {{2{tgt[W-1]}}, tgt} - {{2{cur[W-1]}}, cur};
      if (BYPASS || ((diff <= STEP_X) && (diff >= -STEP_X))) nxt = tgt;
      else if (diff > STEP_X)                                  nxt = cur + STEP_W;
      else                                                     nxt = cur - STEP_W;
   end
endmodule

// File: rtl/distortion_ctrl.sv
// Distortion parameter controller: mode changes crossfade out/switch/in, same-mode changes
// ramp on sample ticks (DISTORTION_CTRL_RAMP_EN) or load one clk after handshake; cfg_ready only in IDLE.
module distortion_ctrl
   import distortion_pkg::*;
#(
   parameter int FADE_STEP = 8,
   parameter int THR_STEP  = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sample_tick,
   distortion_ctrl_if.slave  bus
);
   localparam logic [7:0] FSTEP = 8'(FADE_STEP);
`ifdef DISTORTION_CTRL_RAMP_EN
   localparam bit RAMP_BYPASS = 1'b0;
`else
   localparam bit RAMP_BYPASS = 1'b1;
   logic load_pend;
`endif

   state_t             state;
   logic signed [15:0] lat_gain;
   logic signed [31:0] lat_thr;
   logic [1:0]         lat_mode;
   logic signed [15:0] gain_nxt;
   logic signed [31:0] thr_nxt;
   logic               hs;

   assign hs = bus.cfg_valid && bus.cfg_ready;

   param_ramp #(.W(16), .STEP(1), .BYPASS(RAMP_BYPASS)) u_gain_ramp (
      .cur(bus.gain), .tgt(lat_gain), .nxt(gain_nxt)
   );

   param_ramp #(.W(32), .STEP(THR_STEP), .BYPASS(RAMP_BYPASS)) u_thr_ramp (
      .cur(bus.threshold), .tgt(lat_thr), .nxt(thr_nxt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         bus.mode      <= MODE_OFF;
         bus.gain      <= GAIN_RST;
         bus.threshold <= THR_RST;
         bus.fade      <= FADE_FULL;
         bus.cfg_ready <= 1'b1;
         bus.busy      <= 1'b0;
         lat_gain      <= '0;
         lat_thr       <= '0;
         lat_mode      <= MODE_OFF;
`ifndef DISTORTION_CTRL_RAMP_EN
         load_pend     <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
`ifndef DISTORTION_CTRL_RAMP_EN
               load_pend <= 1'b0;
               if (load_pend) begin
                  bus.gain      <= gain_nxt;
                  bus.threshold <= thr_nxt;
               end
`endif
               if (hs) begin
                  lat_gain <= clamp_gain(bus.gain_tgt);
                  lat_thr  <= clamp_thr(bus.thr_tgt);
                  lat_mode <= bus.mode_tgt;
                  if (bus.mode_tgt != bus.mode) begin
                     state         <= ST_FADE_OUT;
                     bus.cfg_ready <= 1'b0;
                     bus.busy      <= 1'b1;
                  end else begin
`ifdef DISTORTION_CTRL_RAMP_EN
                     state         <= ST_RAMP;
                     bus.cfg_ready <= 1'b0;
                     bus.busy      <= 1'b1;
`else
                     load_pend     <= 1'b1;
`endif
                  end
               end
            end
            ST_FADE_OUT: begin
               if (bus.fade == 8'd0)  state    <= ST_SWITCH;
               else if (sample_tick)  bus.fade <= (bus.fade > FSTEP) ? bus.fade - FSTEP : 8'd0;
            end
            ST_SWITCH: begin
               // output is muted here, so the mode and parameters can jump together
               bus.mode      <= lat_mode;
               bus.gain      <= lat_gain;
               bus.threshold <= lat_thr;
               state         <= ST_FADE_IN;
            end
            ST_FADE_IN: begin
               if (bus.fade == FADE_FULL) begin
                  state         <= ST_IDLE;
                  bus.cfg_ready <= 1'b1;
                  bus.busy      <= 1'b0;
               end else if (sample_tick) begin
                  bus.fade <= (bus.fade < (FADE_FULL - FSTEP)) ? bus.fade + FSTEP : FADE_FULL;
               end
            end
`ifdef DISTORTION_CTRL_RAMP_EN
            ST_RAMP: begin
               if ((bus.gain == lat_gain) && (bus.threshold == lat_thr)) begin
                  state         <= ST_IDLE;
                  bus.cfg_ready <= 1'b1;
                  bus.busy      <= 1'b0;
               end else if (sample_tick) begin
                  bus.gain      <= gain_nxt;
                  bus.threshold <= thr_nxt;
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: doc/distortion_ctrl.md
DISTORTION_CTRL -- requirements
Module: distortion_ctrl

Interface
REQ-001 Parameter FADE_STEP, default 8, fade-level change per sample tick during mode crossfade.
REQ-002 Parameter THR_STEP, default 256, threshold change per sample tick during a parameter ramp.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 sample_tick  input  1  one-clk pulse per stereo audio frame.
REQ-006 cfg_valid  input  1  new configuration offered.
REQ-007 cfg_ready  output  1  controller can accept configuration.
REQ-008 gain_tgt  input  16 signed  requested gain numerator.
REQ-009 thr_tgt  input  32 signed  requested clip threshold.
REQ-010 mode_tgt  input  2  requested mode (0 off, 1/3 clip, 2 rectify).
REQ-011 gain  output  16 signed  gain driven to distortion datapath.
REQ-012 threshold  output  32 signed  threshold driven to datapath.
REQ-013 mode  output  2  mode driven to datapath.
REQ-014 fade  output  8  downstream output level, 255 = unity, 0 = mute.
REQ-015 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-016 Handshake SHALL complete on a clk edge with cfg_valid and cfg_ready both high; cfg_ready SHALL be high only in IDLE, so cfg_valid while busy is ignored.
REQ-017 Accepted targets SHALL be clamped and latched: gain_tgt to 0..128, thr_tgt negative to 0.
REQ-018 FSM states SHALL be IDLE, FADE_OUT, SWITCH, FADE_IN, RAMP.
REQ-019 IDLE: on handshake, latched mode target differing from mode SHALL go to FADE_OUT next cycle, else RAMP next cycle.
REQ-020 FADE_OUT: on each sample_tick fade SHALL decrease by FADE_STEP, saturating at 0; on the clk after fade reaches 0, go to SWITCH.
REQ-021 SWITCH SHALL last exactly one clk regardless of sample_tick, loading mode, gain and threshold from latched targets, then go to FADE_IN.
REQ-022 FADE_IN: on each sample_tick fade SHALL increase by FADE_STEP, saturating at 255; on the clk after fade reaches 255, go to IDLE.
REQ-023 RAMP: on each sample_tick gain SHALL move 1 toward target and threshold THR_STEP toward target, never overshooting; on the clk after both equal target, go to IDLE.
REQ-024 A handshake whose targets equal current outputs SHALL pass through RAMP for one clk and return to IDLE without output change.
REQ-025 Outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-026 reset_n low SHALL immediately force state IDLE, mode 0, gain 1, threshold 32767, fade 255, cfg_ready 1, busy 0, latched targets cleared, including mid-fade or mid-ramp.

Configuration
REQ-027 With DISTORTION_CTRL_RAMP_EN defined, same-mode changes SHALL ramp per REQ-023.
REQ-028 Without DISTORTION_CTRL_RAMP_EN, the RAMP state SHALL be absent and same-mode changes SHALL load gain and threshold on the clk after handshake, staying in IDLE with cfg_ready high.

Structure
REQ-029 Package distortion_pkg SHALL hold mode encoding constants (MODE_OFF, MODE_CLIP, MODE_RECT, MODE_CLIP_ALT), state enum, GAIN_MAX = 128, FADE_FULL = 255.
REQ-030 Sub-module param_ramp (step toward target with no-overshoot clamp, width and step parameterised) SHALL be instantiated for gain and threshold.

Verification
REQ-031 Reset then idle -> mode 0, gain 1, threshold 32767, fade 255, cfg_ready 1.
REQ-032 mode 0 to mode_tgt 1, gain_tgt 4, thr_tgt 1000, ticks every 4 clk -> fade 255 down to 0 over 32 ticks, one SWITCH clk loads 1/4/1000, fade back to 255 in 32 ticks, busy low after.
REQ-033 RAMP_EN, mode 1 gain 4 to gain_tgt 10, thr 1000 to thr_tgt 1600 -> gain reaches 10 after 6 ticks, threshold 1256, 1512, 1600 after 3 ticks, IDLE after tick 6; without macro both load one clk after handshake.
REQ-034 gain_tgt 200 and thr_tgt -5 -> latched/driven 128 and 0.
REQ-035 cfg_valid held during FADE_OUT with different values -> ignored, cfg_ready low, original targets applied.
REQ-036 reset_n pulsed low mid-FADE_IN at fade 64 -> all outputs return to reset values immediately.
